// File: rtl/soc_rib_xbar_pkg.sv
// Shared constants for the RIB memory-mapped crossbar:
// FSM encodings, arbitration modes and default slave codes.
package soc_rib_xbar_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int SLV_RAM = 0;
    localparam int SLV_ROM = 1;

endpackage

// File: rtl/soc_bus_arbiter.sv
// Request arbiter for the RIB crossbar: fixed priority or round-robin.
// The round-robin pointer moves past the winner on every granted advance.
module soc_bus_arbiter
    import soc_rib_xbar_pkg::*;
#(
    parameter int N    = 2,
    parameter int MODE = ARB_FIXED,
    localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found;
    logic [IW-1:0] jj;
    int            j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int i = 0; i < N; i++) begin
            j = (MODE == ARB_RR) ? int'(ptr_q) + i : i;
            if (j >= N) j = j - N;
            jj = IW'(j);
            if (!found && req[jj]) begin
                found     = 1'b1;
                grant[jj] = 1'b1;
                idx       = jj;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (int'(idx) == N - 1) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/soc_rib_xbar.sv
// Multi-master / multi-slave memory-mapped bus, one transaction at a time,
// with address decode, slave timeout and registered response.
module soc_rib_xbar
    import soc_rib_xbar_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int SEL_BITS    = 4,
    parameter int ARB_MODE    = ARB_FIXED,
    parameter int TIMEOUT     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_MASTERS-1:0]      m_req_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_addr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_wdata_i,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic                        m_err_o,
    output logic [DW-1:0]               m_rdata_o,
    output logic [NUM_SLAVES-1:0]       s_req_o,
    output logic                        s_we_o,
    output logic [AW-1:0]               s_addr_o,
    output logic [DW-1:0]               s_wdata_o,
    input  logic [NUM_SLAVES-1:0]       s_ack_i,
    input  logic [NUM_SLAVES*DW-1:0]    s_rdata_i
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST =
        (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [1:0]             state_q, state_d;
    logic [IW-1:0]          win_q, win_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0]  s_req_q, s_req_d;
    logic                   s_we_q, s_we_d;
    logic [AW-1:0]          s_addr_q, s_addr_d;
    logic [DW-1:0]          s_wdata_q, s_wdata_d;
    logic [NUM_MASTERS-1:0] m_ack_q, m_ack_d;
    logic                   m_err_q, m_err_d;
    logic [DW-1:0]          m_rdata_q, m_rdata_d;

    logic                   advance;
    logic [NUM_MASTERS-1:0] grant;
    logic [IW-1:0]          idx;
    logic [AW-1:0]          g_addr;
    logic [SEL_BITS-1:0]    g_sel;
    logic                   g_mapped;
    logic                   ack_hit;
    logic                   timed_out;
    logic [DW-1:0]          rd_mux;

    soc_bus_arbiter #(
        .N    (NUM_MASTERS),
        .MODE (ARB_MODE)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (m_req_i),
        .advance (advance),
        .grant   (grant),
        .idx     (idx)
    );

    assign g_addr   = m_addr_i[idx*AW +: AW];
    assign g_sel    = g_addr[AW-1 -: SEL_BITS];
    assign g_mapped = int'(g_sel) < NUM_SLAVES;

    // Only the selected slave may complete; s_req_q is one-hot in ISSUE.
    always_comb begin
        ack_hit = |(s_ack_i & s_req_q);
        rd_mux  = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (s_req_q[k]) rd_mux = rd_mux | s_rdata_i[k*DW +: DW];
        end
    end

    assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        s_req_d   = s_req_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        m_ack_d   = '0;
        m_err_d   = 1'b0;
        m_rdata_d = '0;
        advance   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|m_req_i) begin
                    advance   = 1'b1;
                    win_d     = idx;
                    s_we_d    = m_we_i[idx];
                    s_addr_d  = g_addr;
                    s_wdata_d = m_wdata_i[idx*DW +: DW];
                    if (g_mapped) begin
                        s_req_d = NUM_SLAVES'(1) << g_sel;
                        cnt_d   = '0;
                        state_d = ST_ISSUE;
                    end else begin
                        m_ack_d = grant;
                        m_err_d = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                if (ack_hit) begin
                    s_req_d   = '0;
                    m_ack_d   = NUM_MASTERS'(1) << win_q;
                    m_rdata_d = s_we_q ? '0 : rd_mux;
                    state_d   = ST_RESP;
                end else if (timed_out) begin
                    s_req_d = '0;
                    m_ack_d = NUM_MASTERS'(1) << win_q;
                    m_err_d = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            win_q     <= '0;
            cnt_q     <= '0;
            s_req_q   <= '0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_ack_q   <= '0;
            m_err_q   <= 1'b0;
            m_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            s_req_q   <= s_req_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            m_ack_q   <= m_ack_d;
            m_err_q   <= m_err_d;
            m_rdata_q <= m_rdata_d;
        end
    end

    assign m_ack_o   = m_ack_q;
    assign m_err_o   = m_err_q;
    assign m_rdata_o = m_rdata_q;
    assign s_req_o   = s_req_q;
    assign s_we_o    = s_we_q;
    assign s_addr_o  = s_addr_q;
    assign s_wdata_o = s_wdata_q;

endmodule
